// File: rtl/ysyx_23060059_rd_arbiter.sv
// rtl/ysyx_23060059_rd_arbiter.sv - two-master (IFU/LSU) AXI4 read-channel arbiter
// Optional round-robin arbitration enabled by YSYX_23060059_ARB_RR_EN; fixed LSU priority otherwise.
module ysyx_23060059_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,

    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic [7:0]        ifu_arlen,
    input  logic [2:0]        ifu_arsize,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic [1:0]        ifu_rresp,
    output logic              ifu_rlast,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,

    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic [7:0]        lsu_arlen,
    input  logic [2:0]        lsu_arsize,
    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [1:0]        lsu_rresp,
    output logic              lsu_rlast,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,

    output logic [ADDR_W-1:0] araddr_o,
    output logic [7:0]        arlen_o,
    output logic [2:0]        arsize_o,
    output logic [1:0]        arburst_o,
    output logic [3:0]        arid_o,
    output logic              arvalid_o,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic              grant;
    logic              arvalid_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [7:0]        arlen_q;
    logic [2:0]        arsize_q;
    logic [3:0]        arid_q;

    logic req_any;
    logic both_req;
    logic pick_lsu;
    logic prefer_lsu;
    logic rready_sel;
    logic r_done;

    assign req_any  = ifu_arvalid | lsu_arvalid;
    assign both_req = ifu_arvalid & lsu_arvalid;
    // Winner only matters when both request; a lone requester always wins.
    assign pick_lsu = lsu_arvalid & (~ifu_arvalid | prefer_lsu);

`ifdef YSYX_23060059_ARB_RR_EN
    logic rr_ptr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr <= 1'b1;
        end else if (state == S_IDLE && both_req) begin
            rr_ptr <= ~pick_lsu;
        end
    end

    assign prefer_lsu = rr_ptr;
`else
    assign prefer_lsu = 1'b1;
`endif

    assign rready_sel = grant ? lsu_rready : ifu_rready;
    assign r_done     = rvalid & rready_sel & rlast;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (req_any) state_next = S_AR;
            S_AR:    if (arready) state_next = S_R;
            S_R:     if (r_done)  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            grant     <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arid_q    <= '0;
        end else if (state == S_IDLE && req_any) begin
            grant     <= pick_lsu;
            arvalid_q <= 1'b1;
            araddr_q  <= pick_lsu ? lsu_araddr : ifu_araddr;
            arlen_q   <= pick_lsu ? lsu_arlen  : ifu_arlen;
            arsize_q  <= pick_lsu ? lsu_arsize : ifu_arsize;
            arid_q    <= {3'b000, pick_lsu};
        end else if (state == S_AR && arready) begin
            arvalid_q <= 1'b0;
        end
    end

    // Handshake outputs are forced low while reset is asserted, even mid-burst.
    always_comb begin
        ifu_arready = 1'b0;
        lsu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_rvalid  = 1'b0;
        rready_o    = 1'b0;
        if (reset) begin
            case (state)
                S_IDLE: begin
                    ifu_arready = ifu_arvalid & ~pick_lsu;
                    lsu_arready = pick_lsu;
                end
                S_R: begin
                    ifu_rvalid = rvalid & ~grant;
                    lsu_rvalid = rvalid & grant;
                    rready_o   = rready_sel;
                end
                default: ;
            endcase
        end
    end

    assign ifu_rdata = rdata;
    assign ifu_rresp = rresp;
    assign ifu_rlast = rlast;
    assign lsu_rdata = rdata;
    assign lsu_rresp = rresp;
    assign lsu_rlast = rlast;

    assign araddr_o  = araddr_q;
    assign arlen_o   = arlen_q;
    assign arsize_o  = arsize_q;
    assign arburst_o = 2'b01;
    assign arid_o    = arid_q;
    assign arvalid_o = arvalid_q;

endmodule

// File: tb/tb_ysyx_23060059_rd_arbiter.sv
// tb/tb_ysyx_23060059_rd_arbiter.sv - randomized self-checking bench for the read arbiter
module tb_ysyx_23060059_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;

    logic          clock;
    logic          reset;
    logic [AW-1:0] ifu_araddr, lsu_araddr;
    logic [7:0]    ifu_arlen, lsu_arlen;
    logic [2:0]    ifu_arsize, lsu_arsize;
    logic          ifu_arvalid, lsu_arvalid;
    logic          ifu_arready, lsu_arready;
    logic [DW-1:0] ifu_rdata, lsu_rdata;
    logic [1:0]    ifu_rresp, lsu_rresp;
    logic          ifu_rlast, lsu_rlast;
    logic          ifu_rvalid, lsu_rvalid;
    logic          ifu_rready, lsu_rready;
    logic [AW-1:0] araddr_o;
    logic [7:0]    arlen_o;
    logic [2:0]    arsize_o;
    logic [1:0]    arburst_o;
    logic [3:0]    arid_o;
    logic          arvalid_o;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready_o;

    ysyx_23060059_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rvalid(ifu_rvalid),
        .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_rdata(lsu_rdata),
        .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rvalid(lsu_rvalid),
        .lsu_rready(lsu_rready),
        .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
        .arid_o(arid_o), .arvalid_o(arvalid_o), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready_o(rready_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Transaction-level reference: pending requests per master plus the preferred master.
    bit            pend_i, pend_l;
    logic [AW-1:0] addr_i, addr_l;
    logic [7:0]    len_i, len_l;
    logic [2:0]    size_i, size_l;
    bit            pref_lsu;
    bit            use_fixed_data;
    logic [DW-1:0] fixed_data;

    task automatic new_req_i(input logic [AW-1:0] a, input logic [7:0] l);
        pend_i = 1'b1; addr_i = a; len_i = l; size_i = 3'($urandom_range(0, 3));
    endtask

    task automatic new_req_l(input logic [AW-1:0] a, input logic [7:0] l);
        pend_l = 1'b1; addr_l = a; len_l = l; size_l = 3'($urandom_range(0, 3));
    endtask

    task automatic drive_ar();
        ifu_arvalid = pend_i; ifu_araddr = addr_i; ifu_arlen = len_i; ifu_arsize = size_i;
        lsu_arvalid = pend_l; lsu_araddr = addr_l; lsu_arlen = len_l; lsu_arsize = size_l;
    endtask

    task automatic check_reset_regs();
        check("rst_arvalid_o", 64'(arvalid_o), 64'd0);
        check("rst_araddr_o", 64'(araddr_o), 64'd0);
        check("rst_arlen_o", 64'(arlen_o), 64'd0);
        check("rst_arsize_o", 64'(arsize_o), 64'd0);
        check("rst_arid_o", 64'(arid_o), 64'd0);
    endtask

    // One full arbitration round from IDLE; rst_beat >= 0 aborts with reset on that beat.
    task automatic run_round(input int rst_beat);
        bit            win_lsu, both;
        logic [AW-1:0] a;
        logic [7:0]    l;
        logic [2:0]    s;
        logic [DW-1:0] d;
        logic [1:0]    rr;
        int            k;
        drive_ar();
        #3;
        both    = pend_i && pend_l;
        win_lsu = pend_l && (!pend_i || pref_lsu);
        check("idle_ifu_arready", 64'(ifu_arready), 64'(pend_i && !win_lsu));
        check("idle_lsu_arready", 64'(lsu_arready), 64'(win_lsu));
        check("idle_rready_o", 64'(rready_o), 64'd0);
        check("idle_rvalids", 64'({ifu_rvalid, lsu_rvalid}), 64'd0);
        if (!pend_i && !pend_l) begin
            tick();
            return;
        end
`ifdef YSYX_23060059_ARB_RR_EN
        if (both) pref_lsu = ~win_lsu;
`else
        if (both) pref_lsu = 1'b1;
`endif
        if (win_lsu) begin
            a = addr_l; l = len_l; s = size_l; pend_l = 1'b0;
        end else begin
            a = addr_i; l = len_i; s = size_i; pend_i = 1'b0;
        end
        tick();
        drive_ar();
        arready = 1'b0;
        k = $urandom_range(0, 5);
        for (int c = 0; c <= k; c++) begin
            if (c == k) arready = 1'b1;
            #3;
            check("ar_arvalid_o", 64'(arvalid_o), 64'd1);
            check("ar_araddr_o", 64'(araddr_o), 64'(a));
            check("ar_arlen_o", 64'(arlen_o), 64'(l));
            check("ar_arsize_o", 64'(arsize_o), 64'(s));
            check("ar_arid_o", 64'(arid_o), 64'(win_lsu));
            check("ar_arburst_o", 64'(arburst_o), 64'd1);
            check("ar_arreadys", 64'({ifu_arready, lsu_arready}), 64'd0);
            tick();
        end
        arready = 1'b0;
        for (int b = 0; b <= int'(l); b++) begin
            k = $urandom_range(0, 2);
            rvalid = 1'b0;
            for (int g = 0; g < k; g++) begin
                ifu_rready = 1'($urandom); lsu_rready = 1'($urandom);
                #3;
                check("gap_rvalids", 64'({ifu_rvalid, lsu_rvalid}), 64'd0);
                check("r_arvalid_o", 64'(arvalid_o), 64'd0);
                tick();
            end
            d = use_fixed_data ? fixed_data : {$urandom, $urandom};
            rr = 2'($urandom);
            rvalid = 1'b1; rdata = d; rresp = rr; rlast = (b == int'(l));
            if (b == rst_beat) begin
                reset = 1'b0;
                ifu_rready = 1'b1; lsu_rready = 1'b1;
                #3;
                check("rstlow_rready_o", 64'(rready_o), 64'd0);
                check("rstlow_rvalids", 64'({ifu_rvalid, lsu_rvalid}), 64'd0);
                check("rstlow_arreadys", 64'({ifu_arready, lsu_arready}), 64'd0);
                tick();
                check_reset_regs();
                reset = 1'b1; rvalid = 1'b0; rlast = 1'b0;
                pend_i = 1'b0; pend_l = 1'b0; pref_lsu = 1'b1;
                drive_ar();
                return;
            end
            k = $urandom_range(0, 2);
            for (int st = 0; st <= k; st++) begin
                if (win_lsu) begin
                    lsu_rready = (st == k); ifu_rready = 1'($urandom);
                end else begin
                    ifu_rready = (st == k); lsu_rready = 1'($urandom);
                end
                #3;
                check("r_rready_o", 64'(rready_o), 64'(st == k));
                check("r_win_rvalid", 64'(win_lsu ? lsu_rvalid : ifu_rvalid), 64'd1);
                check("r_lose_rvalid", 64'(win_lsu ? ifu_rvalid : lsu_rvalid), 64'd0);
                check("r_rdata", win_lsu ? lsu_rdata : ifu_rdata, d);
                check("r_rresp", 64'(win_lsu ? lsu_rresp : ifu_rresp), 64'(rr));
                check("r_rlast", 64'(win_lsu ? lsu_rlast : ifu_rlast), 64'(b == int'(l)));
                check("r_arreadys", 64'({ifu_arready, lsu_arready}), 64'd0);
                tick();
            end
        end
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        rdata = '0; rresp = '0; ifu_rready = 1'b1; lsu_rready = 1'b1;
        pend_i = 1'b1; pend_l = 1'b1; addr_i = 32'h1234; addr_l = 32'h5678;
        len_i = 8'd0; len_l = 8'd0; size_i = 3'd2; size_l = 3'd3;
        pref_lsu = 1'b1; use_fixed_data = 1'b0; fixed_data = '0;
        drive_ar();
        tick(); tick();
        #3;
        check("rstlow_arreadys0", 64'({ifu_arready, lsu_arready}), 64'd0);
        check_reset_regs();
        pend_i = 1'b0; pend_l = 1'b0;
        drive_ar();
        reset = 1'b1;
        tick();

        // IFU only, single beat with a known pattern
        use_fixed_data = 1'b1; fixed_data = 64'h1122_3344_5566_7788;
        new_req_i(32'h8000_0000, 8'd0);
        run_round(-1);
        use_fixed_data = 1'b0;

        // Simultaneous requests, two rounds
        new_req_i(32'h8000_0000, 8'd0);
        new_req_l(32'ha000_0048, 8'd1);
        run_round(-1);
        run_round(-1);

        // LSU 4-beat burst, then reset during beat 2 of another 4-beat burst
        new_req_l(32'h3000_0000, 8'd3);
        run_round(-1);
        new_req_l(32'h3000_0100, 8'd3);
        run_round(1);
        #3;
        check("post_rst_arreadys", 64'({ifu_arready, lsu_arready}), 64'd0);
        tick();
        new_req_i(32'h8000_0040, 8'd2);
        run_round(-1);

        for (int n = 0; n < 80; n++) begin
            if (!pend_i && $urandom_range(0, 1) == 1) new_req_i($urandom, 8'($urandom_range(0, 3)));
            if (!pend_l && $urandom_range(0, 1) == 1) new_req_l($urandom, 8'($urandom_range(0, 3)));
            run_round(-1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
